pll_reconf_seq: RTL and testbench

Sequencer that owns the reconfigurable PLL feeding the DUT clock domain. It accepts a frequency-configuration request from the test controller. It then parks the DUT clock on the safe clock, loads and triggers the PLL, holds the PLL in reset, and waits for a stable lock with a timeout. Only then does it switch the DUT back onto the PLL clock. It also monitors lock while the PLL clock is in use and falls back to the safe clock on lock loss.

---
 rtl/pll_reconf_seq.sv | 233 +++++++++++++++++++++++
 tb/tb_pll_reconf_seq.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/pll_reconf_seq.sv
// pll_reconf_seq: reconfigures the PLL feeding the DUT clock domain.
// Parks the DUT on the safe clock, loads/resets the PLL, waits for lock.
//
// Ports:
//   clock, reset   system clock, async active-high reset
//   req, cfg_data  configuration request and word (taken in IDLE only)
//   abort          cancels a sequence in progress
//   busy           high whenever the sequencer is not idle
//   done           one-cycle pulse at the end of every sequence
//   error          sticky failure flag (timeout, abort, lock loss)
//   lock_lost      sticky flag for lock loss while on the PLL clock
//   pll_data       configuration word to the PLL
//   pll_trigger    one-cycle load strobe to the PLL
//   pll_reset      PLL reset
//   pll_switch     1 = DUT on PLL clock, 0 = safe clock
//   pll_locked     PLL lock indicator, synchronous to clock

module pll_reconf_seq #(
  parameter int PLL_DATA_WIDTH = 16,
  parameter int RESET_CYCLES   = 8,
  parameter int LOCK_STABLE    = 16,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      req,
  input  logic [PLL_DATA_WIDTH-1:0] cfg_data,
  input  logic                      abort,
  output logic                      busy,
  output logic                      done,
  output logic                      error,
  output logic                      lock_lost,
  output logic [PLL_DATA_WIDTH-1:0] pll_data,
  output logic                      pll_trigger,
  output logic                      pll_reset,
  output logic                      pll_switch,
  input  logic                      pll_locked
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    SWITCH_OFF = 3'd1,
    TRIGGER    = 3'd2,
    PLL_RST    = 3'd3,
    WAIT_LOCK  = 3'd4,
    SWITCH_ON  = 3'd5,
    FAIL       = 3'd6
  } state_t;

  localparam logic [CNT_WIDTH-1:0] RST_LAST =
    CNT_WIDTH'(RESET_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] STB_LAST =
    CNT_WIDTH'(LOCK_STABLE - 1);
  localparam logic [CNT_WIDTH-1:0] TMO_LAST =
    CNT_WIDTH'(TIMEOUT_CYCLES);

  state_t state;
  state_t state_nx;

  logic [CNT_WIDTH-1:0] rst_cnt_q;
  logic [CNT_WIDTH-1:0] rst_cnt_d;
  logic [CNT_WIDTH-1:0] stb_cnt_q;
  logic [CNT_WIDTH-1:0] stb_cnt_d;
  logic [CNT_WIDTH-1:0] tmo_cnt_q;
  logic [CNT_WIDTH-1:0] tmo_cnt_d;

  logic                      busy_q;
  logic                      busy_d;
  logic                      done_q;
  logic                      done_d;
  logic                      err_q;
  logic                      err_d;
  logic                      lost_q;
  logic                      lost_d;
  logic [PLL_DATA_WIDTH-1:0] data_q;
  logic [PLL_DATA_WIDTH-1:0] data_d;
  logic                      trig_q;
  logic                      trig_d;
  logic                      prst_q;
  logic                      prst_d;
  logic                      sw_q;
  logic                      sw_d;

  logic stb_hit;
  logic tmo_hit;
  logic abort_ok;

  // stb_hit fires on the cycle whose locked sample completes the run.
  assign stb_hit  = pll_locked && (stb_cnt_q == STB_LAST);
  assign tmo_hit  = (tmo_cnt_q == TMO_LAST);
  assign abort_ok = abort && (state != IDLE) && (state != FAIL);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      rst_cnt_q <= '0;
      stb_cnt_q <= '0;
      tmo_cnt_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      lost_q    <= 1'b0;
      data_q    <= '0;
      trig_q    <= 1'b0;
      prst_q    <= 1'b0;
      sw_q      <= 1'b0;
    end else begin
      state     <= state_nx;
      rst_cnt_q <= rst_cnt_d;
      stb_cnt_q <= stb_cnt_d;
      tmo_cnt_q <= tmo_cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      lost_q    <= lost_d;
      data_q    <= data_d;
      trig_q    <= trig_d;
      prst_q    <= prst_d;
      sw_q      <= sw_d;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (req) begin
          state_nx = SWITCH_OFF;
        end
      end
      SWITCH_OFF: begin
        state_nx = TRIGGER;
      end
      TRIGGER: begin
        state_nx = PLL_RST;
      end
      PLL_RST: begin
        if (rst_cnt_q == RST_LAST) begin
          state_nx = WAIT_LOCK;
        end
      end
      WAIT_LOCK: begin
        if (stb_hit) begin
          state_nx = SWITCH_ON;
        end else if (tmo_hit) begin
          state_nx = FAIL;
        end
      end
      SWITCH_ON: begin
        state_nx = IDLE;
      end
      FAIL: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
    if (abort_ok) begin
      state_nx = FAIL;
    end
  end

  // Output and counter next-values. Counters default to zero so
  // every state entry starts them cleared.
  always_comb begin
    busy_d    = (state != IDLE);
    done_d    = 1'b0;
    err_d     = err_q;
    lost_d    = lost_q;
    data_d    = data_q;
    trig_d    = 1'b0;
    prst_d    = 1'b0;
    sw_d      = sw_q;
    rst_cnt_d = '0;
    stb_cnt_d = '0;
    tmo_cnt_d = '0;
    unique case (state)
      IDLE: begin
        if (sw_q && !pll_locked) begin
          sw_d   = 1'b0;
          err_d  = 1'b1;
          lost_d = 1'b1;
        end
        // An accepted request overrides lock-loss flags.
        if (req) begin
          data_d = cfg_data;
          err_d  = 1'b0;
          lost_d = 1'b0;
        end
      end
      SWITCH_OFF: begin
        sw_d = 1'b0;
      end
      TRIGGER: begin
        trig_d = !abort;
      end
      PLL_RST: begin
        prst_d    = !abort;
        rst_cnt_d = rst_cnt_q + 1'b1;
      end
      WAIT_LOCK: begin
        stb_cnt_d = pll_locked ? stb_cnt_q + 1'b1 : '0;
        tmo_cnt_d = tmo_cnt_q + 1'b1;
      end
      SWITCH_ON: begin
        if (!abort) begin
          sw_d   = 1'b1;
          done_d = 1'b1;
        end
      end
      FAIL: begin
        sw_d   = 1'b0;
        err_d  = 1'b1;
        done_d = 1'b1;
      end
      default: begin
        sw_d = 1'b0;
      end
    endcase
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign error       = err_q;
  assign lock_lost   = lost_q;
  assign pll_data    = data_q;
  assign pll_trigger = trig_q;
  assign pll_reset   = prst_q;
  assign pll_switch  = sw_q;

endmodule

// File: tb/tb_pll_reconf_seq.sv
// tb_pll_reconf_seq: directed bench for pll_reconf_seq.
// Cycle counts are measured from the edge that samples req.

module tb_pll_reconf_seq;

  logic        clock;
  logic        reset;
  logic        req;
  logic [15:0] cfg_data;
  logic        abort;
  logic        busy;
  logic        done;
  logic        error;
  logic        lock_lost;
  logic [15:0] pll_data;
  logic        pll_trigger;
  logic        pll_reset;
  logic        pll_switch;
  logic        pll_locked;

  int n_chk;
  int n_pass;

  int d_at;
  int t_n;
  int t_at;
  int r_n;
  int r_at;

  pll_reconf_seq #(
    .TIMEOUT_CYCLES(100)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .req        (req),
    .cfg_data   (cfg_data),
    .abort      (abort),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .lock_lost  (lock_lost),
    .pll_data   (pll_data),
    .pll_trigger(pll_trigger),
    .pll_reset  (pll_reset),
    .pll_switch (pll_switch),
    .pll_locked (pll_locked)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic [15:0] d);
    req      = 1'b1;
    cfg_data = d;
    step();
    req      = 1'b0;
  endtask

  // Runs up to max cycles after the req edge, stops on done.
  // glitch_at > 0 drops pll_locked for one sample after that cycle.
  task automatic watch(input int max, input int glitch_at,
                       output int done_at,
                       output int trig_n, output int trig_at,
                       output int rst_n, output int rst_at);
    done_at = -1;
    trig_n  = 0;
    trig_at = -1;
    rst_n   = 0;
    rst_at  = -1;
    for (int k = 1; k <= max; k++) begin
      step();
      if (glitch_at > 0 && k == glitch_at) pll_locked = 1'b0;
      if (glitch_at > 0 && k == glitch_at + 1) pll_locked = 1'b1;
      if (pll_trigger) begin
        trig_n++;
        if (trig_at < 0) trig_at = k;
      end
      if (pll_reset) begin
        rst_n++;
        if (rst_at < 0) rst_at = k;
      end
      if (done) begin
        done_at = k;
        break;
      end
    end
  endtask

  initial begin
    n_chk      = 0;
    n_pass     = 0;
    reset      = 1'b1;
    req        = 1'b0;
    cfg_data   = 16'h0;
    abort      = 1'b0;
    pll_locked = 1'b1;

    repeat (3) step();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_flags", {error, lock_lost}, 0);
    chk("rst_data", pll_data, 0);
    chk("rst_pll", {pll_trigger, pll_reset, pll_switch}, 0);
    reset = 1'b0;
    step();

    // nominal
    issue(16'h1234);
    chk("nom_data", pll_data, 16'h1234);
    watch(40, 0, d_at, t_n, t_at, r_n, r_at);
    chk("nom_trig_n", t_n, 1);
    chk("nom_trig_at", t_at, 2);
    chk("nom_rst_n", r_n, 8);
    chk("nom_rst_at", r_at, 3);
    chk("nom_done_at", d_at, 27);
    chk("nom_sw", pll_switch, 1);
    chk("nom_err", error, 0);
    chk("nom_busy_at_done", busy, 1);
    step();
    chk("nom_done_pulse", done, 0);
    chk("nom_busy_end", busy, 0);

    // abort in IDLE does nothing
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("idle_abort_busy", busy, 0);
    step();
    chk("idle_abort_done", done, 0);
    chk("idle_abort_sw", pll_switch, 1);
    chk("idle_abort_err", error, 0);

    // lock loss while switched in
    pll_locked = 1'b0;
    step();
    pll_locked = 1'b1;
    chk("loss_sw", pll_switch, 0);
    chk("loss_err", error, 1);
    chk("loss_flag", lock_lost, 1);
    chk("loss_done", done, 0);
    step();
    chk("loss_done2", done, 0);
    chk("loss_busy", busy, 0);

    // lock glitch in WAIT_LOCK
    issue(16'h5678);
    chk("gl_clr", {error, lock_lost}, 0);
    watch(60, 20, d_at, t_n, t_at, r_n, r_at);
    chk("gl_done_at", d_at, 38);
    chk("gl_sw", pll_switch, 1);
    chk("gl_data", pll_data, 16'h5678);
    step();

    // req on the lock-loss cycle, then timeout with no lock
    pll_locked = 1'b0;
    issue(16'h9abc);
    chk("ll_req_flags", {error, lock_lost}, 0);
    chk("ll_req_sw", pll_switch, 0);
    chk("ll_req_data", pll_data, 16'h9abc);
    watch(150, 0, d_at, t_n, t_at, r_n, r_at);
    chk("tmo_trig_at", t_at, 2);
    chk("tmo_rst_n", r_n, 8);
    chk("tmo_done_at", d_at, 112);
    chk("tmo_err", error, 1);
    chk("tmo_sw", pll_switch, 0);
    chk("tmo_lost", lock_lost, 0);
    step();
    chk("tmo_done_pulse", done, 0);

    // new req clears error; busy req ignored; abort in PLL_RST
    pll_locked = 1'b1;
    issue(16'h0f0f);
    chk("ab_err_clr", error, 0);
    step();
    req      = 1'b1;
    cfg_data = 16'hffff;
    step();
    req      = 1'b0;
    chk("busy_req_data", pll_data, 16'h0f0f);
    step();
    step();
    chk("ab_rst_before", pll_reset, 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("ab_rst_drop", pll_reset, 0);
    chk("ab_done_early", done, 0);
    chk("ab_busy", busy, 1);
    step();
    chk("ab_done", done, 1);
    chk("ab_err", error, 1);
    chk("ab_sw", pll_switch, 0);
    step();
    chk("ab_done_pulse", done, 0);
    chk("ab_busy_end", busy, 0);
    chk("ab_err_sticky", error, 1);

    // async reset during WAIT_LOCK
    issue(16'h4321);
    repeat (15) step();
    chk("ar_busy_pre", busy, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("ar_busy", busy, 0);
    chk("ar_data", pll_data, 0);
    chk("ar_outs",
        {done, error, lock_lost, pll_trigger, pll_reset, pll_switch},
        0);
    step();
    reset = 1'b0;
    step();
    issue(16'hbeef);
    chk("ar_nom_data", pll_data, 16'hbeef);
    watch(40, 0, d_at, t_n, t_at, r_n, r_at);
    chk("ar_nom_trig_n", t_n, 1);
    chk("ar_nom_rst_n", r_n, 8);
    chk("ar_nom_done_at", d_at, 27);
    chk("ar_nom_sw", pll_switch, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
